// File: rtl/abc_input_conditioner.sv
// abc_input_conditioner: synchronizes and debounces raw a/b/c lines for the JK/SR sequence FSM.
// Ports:
//   clk                      rising-edge system clock
//   reset_n                  asynchronous active-low reset
//   a_raw, b_raw, c_raw      raw asynchronous inputs
//   a, b, c                  debounced registered levels
//   abc_all                  a & b & c, combinational from the output registers
//   changed                  one-cycle pulse in the first cycle any of a/b/c takes a new value
//   glitch_cnt [7:0]         saturating count of aborted debounce attempts (only with ABC_GLITCH_CNT_EN)
// Optional feature macro: ABC_GLITCH_CNT_EN
module abc_input_conditioner #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       a_raw,
    input  logic       b_raw,
    input  logic       c_raw,
    output logic       a,
    output logic       b,
    output logic       c,
    output logic       abc_all,
    output logic       changed
`ifdef ABC_GLITCH_CNT_EN
    ,
    output logic [7:0] glitch_cnt
`endif
);
    localparam int CW = ($clog2(DEBOUNCE_CYCLES + 1) < 1) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [2:0]    raw, s1, s2, out, upd;
    logic [CW-1:0] cnt [3];

    assign raw     = {c_raw, b_raw, a_raw};
    assign {c, b, a} = out;
    assign abc_all = &out;

    always_comb begin
        upd = '0;
        for (int i = 0; i < 3; i++)
            upd[i] = (s2[i] != out[i]) && (cnt[i] == LAST);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1      <= '0;
            s2      <= '0;
            out     <= '0;
            changed <= 1'b0;
            for (int i = 0; i < 3; i++)
                cnt[i] <= '0;
        end else begin
            s1      <= raw;
            s2      <= s1;
            changed <= |upd;
            for (int i = 0; i < 3; i++) begin
                if (s2[i] == out[i]) begin
                    cnt[i] <= '0;
                end else if (upd[i]) begin
                    out[i] <= s2[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CW'(1);
                end
            end
        end
    end

`ifdef ABC_GLITCH_CNT_EN
    logic [2:0] abort;
    logic [8:0] gsum;

    // An attempt is aborted when a partially counted mismatch disappears.
    always_comb begin
        abort = '0;
        for (int i = 0; i < 3; i++)
            abort[i] = (s2[i] == out[i]) && (cnt[i] != '0);
        gsum = {1'b0, glitch_cnt} + 9'(abort[0]) + 9'(abort[1]) + 9'(abort[2]);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            glitch_cnt <= '0;
        else
            glitch_cnt <= gsum[8] ? 8'hff : gsum[7:0];
    end
`endif

endmodule

// File: tb/tb_abc_input_conditioner.sv
// tb_abc_input_conditioner: scoreboard bench for abc_input_conditioner with DEBOUNCE_CYCLES=4.
module tb_abc_input_conditioner;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic a_raw = 1'b1, b_raw = 1'b1, c_raw = 1'b1;
    logic a, b, c, abc_all, changed;
`ifdef ABC_GLITCH_CNT_EN
    logic [7:0] glitch_cnt;
    int gexp = 0;
`endif

    typedef struct {
        int         when;
        logic [4:0] v;
        string      tag;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int cyc = 0;
    int checks = 0;
    int failures = 0;
    logic [2:0] cur = 3'b000;

    abc_input_conditioner #(.DEBOUNCE_CYCLES(4)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .a_raw(a_raw),
        .b_raw(b_raw),
        .c_raw(c_raw),
        .a(a),
        .b(b),
        .c(c),
        .abc_all(abc_all),
        .changed(changed)
`ifdef ABC_GLITCH_CNT_EN
        ,
        .glitch_cnt(glitch_cnt)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s obs=%0h exp=%0h cyc=%0d", tag, obs, exp, cyc);
        end
    endtask

    // v is {c,b,a}; packed as {a,b,c,abc_all,changed} to match the observed vector
    function automatic logic [4:0] mk(input logic [2:0] v, input logic chg);
        return {v[0], v[1], v[2], &v, chg};
    endfunction

    function automatic logic [4:0] obs_vec();
        return {a, b, c, abc_all, changed};
    endfunction

    task automatic push(input int when, input logic [4:0] v, input string tag);
        exp_t e;
        e.when = when;
        e.v    = v;
        e.tag  = tag;
        q.push_back(e);
    endtask

    always @(negedge clk) begin
        while (q.size() != 0 && q[0].when <= cyc) begin
            mon_e = q.pop_front();
            check(mon_e.tag, 32'(obs_vec()), 32'(mon_e.v));
        end
    end

    task automatic drain();
        int t = 0;
        while (q.size() != 0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (q.size() != 0) begin
            check("drain_timeout", q.size(), 0);
            q.delete();
        end
        @(negedge clk);
    endtask

    // Raw change captured at edge n+1 shows on the outputs from edge n+6.
    task automatic step_to(input logic [2:0] v, input string tag);
        int n;
        @(negedge clk);
        {c_raw, b_raw, a_raw} = v;
        n = cyc;
        push(n + 5, mk(cur, 1'b0), {tag, "_pre"});
        push(n + 6, mk(v, 1'b1), {tag, "_edge"});
        push(n + 7, mk(v, 1'b0), {tag, "_post"});
        cur = v;
        drain();
    endtask

    initial begin
        int n;
        repeat (3) @(negedge clk);
        check("rst_hold", 32'(obs_vec()), 0);
        reset_n = 1'b1;
        n = cyc;
        push(n + 5, mk(3'b000, 1'b0), "rel_pre");
        push(n + 6, mk(3'b111, 1'b1), "rel_edge");
        push(n + 7, mk(3'b111, 1'b0), "rel_post");
        cur = 3'b111;
        drain();
        step_to(3'b000, "fall_all");

        step_to(3'b001, "a_rise");
        step_to(3'b000, "a_fall");

        @(negedge clk);
        b_raw = 1'b1;
        n = cyc;
        for (int i = 1; i <= 10; i++)
            push(n + i, mk(3'b000, 1'b0), "b_glitch");
        repeat (2) @(negedge clk);
        b_raw = 1'b0;
        drain();
`ifdef ABC_GLITCH_CNT_EN
        gexp++;
        check("glitch_cnt_b", 32'(glitch_cnt), 32'(gexp));
`endif

        step_to(3'b111, "simul_rise");
        step_to(3'b000, "simul_fall");

        @(negedge clk);
        c_raw = 1'b1;
        repeat (3) @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("mid_rst", 32'(obs_vec()), 0);
        @(negedge clk);
        reset_n = 1'b1;
        n = cyc;
        push(n + 5, mk(3'b000, 1'b0), "mid_pre");
        push(n + 6, mk(3'b100, 1'b1), "mid_edge");
        push(n + 7, mk(3'b100, 1'b0), "mid_post");
        cur = 3'b100;
        drain();
`ifdef ABC_GLITCH_CNT_EN
        gexp = 0;
        check("glitch_cnt_rst", 32'(glitch_cnt), 32'(gexp));
`endif
        step_to(3'b000, "c_fall");

`ifdef ABC_GLITCH_CNT_EN
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            a_raw = 1'b1;
            push(cyc + 3, mk(3'b000, 1'b0), "sat_a_low");
            repeat (2) @(negedge clk);
            a_raw = 1'b0;
            repeat (2) @(negedge clk);
            gexp = (gexp < 255) ? gexp + 1 : 255;
        end
        drain();
        check("glitch_cnt_sat", 32'(glitch_cnt), 32'(gexp));
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
